vga_stream_scanout: RTL

- Single-clock VGA scan-out engine for the display path.
- Accepts a pixel stream into an internal FIFO and holds the raster idle until the FIFO reaches a start threshold. It then emits sync, blank, and pixel data using fully parametrised timing, colour width and sync polarity.
- Successor to the fixed 640x480 FIFO-plus-reader-plus-pixel-logic path. Adds a pixel-clock enable, underflow detection and optional frame resynchronisation.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_sync_fifo.sv | 56 +++++
 rtl/vga_stream_scanout.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA scan-out path.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package vga_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // 640x480@60 reference timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int h_total(input int active, input int fp, input int sw, input int bp);
    return active + fp + sw + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sw, input int bp);
    return active + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_sync_fifo.sv
// Single-clock FIFO, no fall-through: head shows the oldest stored word.
// Latency: a pushed word is visible at head on the edge after the push.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, reset (async active-low), push/push_data, pop, head, empty, full, level.
module vga_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // simultaneous push and pop leaves the level unchanged
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_stream_scanout.sv
// VGA scan-out: buffers a pixel stream, starts the raster at a fill threshold, emits sync/blank/pixel.
// Latency: outputs reflect the (h,v) counters one enabled pix_ce edge later; first pixel two edges after threshold.
// Backpressure: in_ready = FIFO not full; starved active pixels drive UNDER_COLOR and set underflow.
// Ports: clk, reset (async active-low), pix_ce, in_data/in_valid/in_ready, freeslots,
//        pixel, hsync, vsync, blank_n, video_on, row, column, frame_start, running,
//        underflow, clr_underflow.
module vga_stream_scanout
  import vga_pkg::*;
#(
  parameter int               PIX_W       = 24,
  parameter int               H_ACTIVE    = DEF_H_ACTIVE,
  parameter int               H_FP        = DEF_H_FP,
  parameter int               H_SYNC      = DEF_H_SYNC,
  parameter int               H_BP        = DEF_H_BP,
  parameter int               V_ACTIVE    = DEF_V_ACTIVE,
  parameter int               V_FP        = DEF_V_FP,
  parameter int               V_SYNC      = DEF_V_SYNC,
  parameter int               V_BP        = DEF_V_BP,
  parameter bit               HS_POL      = 1'b0,
  parameter bit               VS_POL      = 1'b0,
  parameter int               FIFO_DEPTH  = 64,
  parameter int               START_LEVEL = 32,
  parameter logic [PIX_W-1:0] UNDER_COLOR = '0,
  parameter bit               RESYNC      = 1'b1,
  parameter int               CW          = 11
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pix_ce,
  input  logic [PIX_W-1:0]            in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [$clog2(FIFO_DEPTH):0] freeslots,
  output logic [PIX_W-1:0]            pixel,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        blank_n,
  output logic                        video_on,
  output logic [CW-1:0]               row,
  output logic [CW-1:0]               column,
  output logic                        frame_start,
  output logic                        running,
  output logic                        underflow,
  input  logic                        clr_underflow
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int LW      = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [CW-1:0]     h;
  logic [CW-1:0]     v;
  logic              frame_bad;

  logic [PIX_W-1:0]  head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [LW-1:0]     level;

  logic              step;
  logic              active;
  logic              h_in_sync;
  logic              v_in_sync;
  logic              end_of_frame;
  logic              pop;
  logic              starve;

  vga_sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (level)
  );

  assign step         = (state == RUN) && pix_ce;
  assign active       = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
  assign h_in_sync    = (h >= CW'(H_ACTIVE + H_FP)) && (h < CW'(H_ACTIVE + H_FP + H_SYNC));
  assign v_in_sync    = (v >= CW'(V_ACTIVE + V_FP)) && (v < CW'(V_ACTIVE + V_FP + V_SYNC));
  assign end_of_frame = (h == CW'(H_TOTAL - 1)) && (v == CW'(V_TOTAL - 1));
  assign pop          = step && active && !fifo_empty;
  assign starve       = step && active && fifo_empty;

  assign in_ready  = !fifo_full;
  assign freeslots = LW'(FIFO_DEPTH) - level;
  assign running   = (state == RUN);
  assign video_on  = blank_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      h           <= '0;
      v           <= '0;
      frame_bad   <= 1'b0;
      pixel       <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      blank_n     <= 1'b0;
      row         <= '0;
      column      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (state == IDLE) begin
        // outputs sit at their reset values while waiting for the fill threshold
        h       <= '0;
        v       <= '0;
        pixel   <= '0;
        hsync   <= ~HS_POL;
        vsync   <= ~VS_POL;
        blank_n <= 1'b0;
        row     <= '0;
        column  <= '0;
        if (level >= LW'(START_LEVEL)) state <= RUN;
      end else if (pix_ce) begin
        row         <= v;
        column      <= h;
        blank_n     <= active;
        frame_start <= (h == '0) && (v == '0);
        hsync       <= h_in_sync ? HS_POL : ~HS_POL;
        vsync       <= v_in_sync ? VS_POL : ~VS_POL;
        pixel       <= !active ? '0 : (fifo_empty ? UNDER_COLOR : head);
        if (starve) frame_bad <= 1'b1;
        // the last position of a frame is never active, so frame_bad cannot be set here
        if (end_of_frame) begin
          h         <= '0;
          v         <= '0;
          frame_bad <= 1'b0;
          if (RESYNC && frame_bad) state <= IDLE;
        end else if (h == CW'(H_TOTAL - 1)) begin
          h <= '0;
          v <= v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  // sticky flag; a new underflow outranks a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             underflow <= 1'b0;
    else if (starve)        underflow <= 1'b1;
    else if (clr_underflow) underflow <= 1'b0;
  end

endmodule
